// File: rtl/mc_sequencer.sv
// Multi-cycle control sequencer: steps each instruction through FETCH/DECODE/EXEC/MEM/WB,
// gates the decoder's enables into their phase, counts retirements and halts on faults.
module mc_sequencer #(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  opcode,
  input  logic [1:0]  ctrlNPCFrom,
  input  logic        ctrlMemRead,
  input  logic        ctrlMemWrite,
  input  logic        ctrlRegWrite,
  output logic        imemReq,
  input  logic        imemAck,
  output logic        dmemReq,
  output logic        dmemWe,
  input  logic        dmemAck,
  output logic        irWrite,
  output logic        pcWrite,
  output logic        aluOutWrite,
  output logic        mdrWrite,
  output logic        regWrite,
  output logic [2:0]  state,
  output logic        halted,
  output logic        busErr,
  output logic [31:0] instret
);

  localparam int WAIT_W = ($clog2(ACK_TIMEOUT + 1) < 1) ? 1 : $clog2(ACK_TIMEOUT + 1);
  localparam bit WD_EN  = (ACK_TIMEOUT != 0);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'((ACK_TIMEOUT == 0) ? 0 : ACK_TIMEOUT - 1);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [1:0] NPC_BRANCH = 2'd1;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] waitCnt_q, waitCnt_d;
  logic [31:0]       instret_q, instret_d;
  logic              busErr_q, busErr_d;
  logic              imemReq_q, imemReq_d;
  logic              dmemReq_q, dmemReq_d;
  logic              dmemWe_q, dmemWe_d;
  logic              halted_q, halted_d;
  logic              legalOp;
  logic              waiting;
  logic              timeoutHit;

  always_comb begin
    legalOp = 1'b0;
    case (opcode)
      OP_RTYPE, OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_LUI, OP_XORI, OP_SW,
      OP_LW, OP_BEQ, OP_BNE, OP_SLTI, OP_SLTIU, OP_J, OP_JAL: legalOp = 1'b1;
      default: legalOp = 1'b0;
    endcase
  end

  // FETCH only counts as waiting once imemReq is up, so the post-reset idle cycle is inert.
  assign waiting    = ((state_q == S_FETCH) && imemReq_q) || (state_q == S_MEM);
  assign timeoutHit = WD_EN && (waitCnt_q == WAIT_LIMIT);

  always_comb begin
    state_d     = state_q;
    busErr_d    = busErr_q;
    irWrite     = 1'b0;
    pcWrite     = 1'b0;
    aluOutWrite = 1'b0;
    mdrWrite    = 1'b0;
    regWrite    = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (imemReq_q) begin
          if (imemAck) begin
            irWrite = 1'b1;
            state_d = S_DECODE;
          end else if (timeoutHit) begin
            state_d  = S_HALT;
            busErr_d = 1'b1;
          end
        end
      end
      S_DECODE: begin
        if (!legalOp) begin
          state_d = S_HALT;
        end else if (opcode == OP_J) begin
          pcWrite = 1'b1;
          state_d = S_FETCH;
        end else if (opcode == OP_JAL) begin
          pcWrite  = 1'b1;
          regWrite = ctrlRegWrite;
          state_d  = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        aluOutWrite = 1'b1;
        if (ctrlNPCFrom == NPC_BRANCH) begin
          pcWrite = 1'b1;
          state_d = S_FETCH;
        end else if (ctrlMemRead || ctrlMemWrite) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (dmemAck) begin
          if (ctrlMemWrite) begin
            pcWrite = 1'b1;
            state_d = S_FETCH;
          end else begin
            mdrWrite = 1'b1;
            state_d  = S_WB;
          end
        end else if (timeoutHit) begin
          state_d  = S_HALT;
          busErr_d = 1'b1;
        end
      end
      S_WB: begin
        regWrite = ctrlRegWrite;
        pcWrite  = 1'b1;
        state_d  = S_FETCH;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_HALT;
    endcase

    instret_d = pcWrite ? instret_q + 32'd1 : instret_q;

    if (state_d != state_q) waitCnt_d = '0;
    else if (waiting)       waitCnt_d = waitCnt_q + 1'b1;
    else                    waitCnt_d = waitCnt_q;

    // Moore outputs are registered from the next state so they are clean and 0 during reset.
    imemReq_d = (state_d == S_FETCH);
    dmemReq_d = (state_d == S_MEM);
    dmemWe_d  = (state_d == S_MEM) && ctrlMemWrite;
    halted_d  = (state_d == S_HALT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      waitCnt_q <= '0;
      instret_q <= '0;
      busErr_q  <= 1'b0;
      imemReq_q <= 1'b0;
      dmemReq_q <= 1'b0;
      dmemWe_q  <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      waitCnt_q <= waitCnt_d;
      instret_q <= instret_d;
      busErr_q  <= busErr_d;
      imemReq_q <= imemReq_d;
      dmemReq_q <= dmemReq_d;
      dmemWe_q  <= dmemWe_d;
      halted_q  <= halted_d;
    end
  end

  assign state   = state_q;
  assign imemReq = imemReq_q;
  assign dmemReq = dmemReq_q;
  assign dmemWe  = dmemWe_q;
  assign halted  = halted_q;
  assign busErr  = busErr_q;
  assign instret = instret_q;

endmodule

// File: tb/tb_mc_sequencer.sv
// Randomized self-checking bench for mc_sequencer: a per-instruction phase model predicts
// every cycle's state, enables and retire count.
module tb_mc_sequencer;

  localparam int TMO = 4;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // Expected-flag bits: {imemReq,dmemReq,dmemWe,irWrite,pcWrite,aluOutWrite,mdrWrite,regWrite,halted,busErr}
  localparam logic [9:0] M_IMEM = 10'b10_0000_0000;
  localparam logic [9:0] M_DMEM = 10'b01_0000_0000;
  localparam logic [9:0] M_WE   = 10'b00_1000_0000;
  localparam logic [9:0] M_IR   = 10'b00_0100_0000;
  localparam logic [9:0] M_PC   = 10'b00_0010_0000;
  localparam logic [9:0] M_ALU  = 10'b00_0001_0000;
  localparam logic [9:0] M_MDR  = 10'b00_0000_1000;
  localparam logic [9:0] M_REG  = 10'b00_0000_0100;
  localparam logic [9:0] M_HALT = 10'b00_0000_0010;
  localparam logic [9:0] M_BERR = 10'b00_0000_0001;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  opcode = '0;
  logic [1:0]  ctrlNPCFrom = '0;
  logic        ctrlMemRead = 1'b0;
  logic        ctrlMemWrite = 1'b0;
  logic        ctrlRegWrite = 1'b0;
  logic        imemAck = 1'b0;
  logic        dmemAck = 1'b0;
  logic        imemReq, dmemReq, dmemWe, irWrite, pcWrite, aluOutWrite, mdrWrite, regWrite;
  logic        halted, busErr;
  logic [2:0]  state;
  logic [31:0] instret;
  logic [9:0]  dutFlags;

  int          compareCount = 0;
  int          failCount = 0;
  logic [31:0] expInstret = '0;
  logic        expBusErr = 1'b0;
  logic [5:0]  legalOps [15] = '{6'h00, 6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0F, 6'h0E, 6'h2B,
                                 6'h23, 6'h04, 6'h05, 6'h0A, 6'h0B, 6'h02, 6'h03};

  mc_sequencer #(.ACK_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .ctrlNPCFrom(ctrlNPCFrom),
    .ctrlMemRead(ctrlMemRead), .ctrlMemWrite(ctrlMemWrite), .ctrlRegWrite(ctrlRegWrite),
    .imemReq(imemReq), .imemAck(imemAck), .dmemReq(dmemReq), .dmemWe(dmemWe), .dmemAck(dmemAck),
    .irWrite(irWrite), .pcWrite(pcWrite), .aluOutWrite(aluOutWrite), .mdrWrite(mdrWrite),
    .regWrite(regWrite), .state(state), .halted(halted), .busErr(busErr), .instret(instret)
  );

  always #5 clk = ~clk;

  assign dutFlags = {imemReq, dmemReq, dmemWe, irWrite, pcWrite, aluOutWrite, mdrWrite,
                     regWrite, halted, busErr};

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // One clock cycle: drive acks just after the edge, sample mid-cycle, advance the retire model.
  task automatic applyStimulus(input logic [2:0] st, input logic [9:0] fl, input logic ia,
                               input logic da, input string tag);
    logic [9:0] want;
    want = fl | (expBusErr ? M_BERR : 10'd0);
    imemAck = ia;
    dmemAck = da;
    #2;
    checkOutput({tag, "/state"}, 32'(state), 32'(st));
    checkOutput({tag, "/flags"}, 32'(dutFlags), 32'(want));
    checkOutput({tag, "/instret"}, instret, expInstret);
    if (fl[5]) expInstret = expInstret + 32'd1;
    @(posedge clk);
    #1;
  endtask

  task automatic releaseReset();
    rst = 1'b0;
    expInstret = '0;
    expBusErr = 1'b0;
    applyStimulus(3'd0, 10'd0, 1'b1, rb(), "idleAfterReset");
  endtask

  task automatic doReset();
    rst = 1'b1;
    #1;
    checkOutput("reset/state", 32'(state), 32'd0);
    checkOutput("reset/flags", 32'(dutFlags), 32'd0);
    checkOutput("reset/instret", instret, 32'd0);
    @(posedge clk);
    #1;
    releaseReset();
  endtask

  task automatic setDecoder(input logic [5:0] op);
    opcode       = op;
    ctrlMemRead  = (op == OP_LW);
    ctrlMemWrite = (op == OP_SW);
    ctrlRegWrite = !(op inside {OP_SW, OP_BEQ, OP_BNE, OP_J});
    ctrlNPCFrom  = (op inside {OP_BEQ, OP_BNE}) ? 2'd1 : (op inside {OP_J, OP_JAL}) ? 2'd2 : 2'd0;
  endtask

  task automatic haltCycles();
    repeat (6) applyStimulus(3'd5, M_HALT, rb(), rb(), "halt");
  endtask

  // Phase model; a wait count of TMO or more means the ack never arrives.
  task automatic runInstr(input logic [5:0] op, input int wi, input int wd);
    logic legal;
    logic [9:0] we;
    legal = 1'b0;
    foreach (legalOps[k]) if (legalOps[k] == op) legal = 1'b1;
    setDecoder(op);
    if (wi >= TMO) begin
      repeat (TMO) applyStimulus(3'd0, M_IMEM, 1'b0, rb(), "fetchTmo");
      expBusErr = 1'b1;
      haltCycles();
      return;
    end
    repeat (wi) applyStimulus(3'd0, M_IMEM, 1'b0, rb(), "fetchWait");
    applyStimulus(3'd0, M_IMEM | M_IR, 1'b1, rb(), "fetchAck");
    if (!legal) begin
      applyStimulus(3'd1, 10'd0, rb(), rb(), "decodeIllegal");
      haltCycles();
      return;
    end
    if (op == OP_J || op == OP_JAL) begin
      applyStimulus(3'd1, M_PC | ((op == OP_JAL) ? M_REG : 10'd0), rb(), rb(), "decodeJump");
      return;
    end
    applyStimulus(3'd1, 10'd0, rb(), rb(), "decode");
    if (op == OP_BEQ || op == OP_BNE) begin
      applyStimulus(3'd2, M_ALU | M_PC, rb(), rb(), "execBranch");
      return;
    end
    applyStimulus(3'd2, M_ALU, rb(), rb(), "exec");
    if (op == OP_LW || op == OP_SW) begin
      we = (op == OP_SW) ? M_WE : 10'd0;
      if (wd >= TMO) begin
        repeat (TMO) applyStimulus(3'd3, M_DMEM | we, rb(), 1'b0, "memTmo");
        expBusErr = 1'b1;
        haltCycles();
        return;
      end
      repeat (wd) applyStimulus(3'd3, M_DMEM | we, rb(), 1'b0, "memWait");
      if (op == OP_SW) begin
        applyStimulus(3'd3, M_DMEM | M_WE | M_PC, rb(), 1'b1, "memStore");
        return;
      end
      applyStimulus(3'd3, M_DMEM | M_MDR, rb(), 1'b1, "memLoad");
    end
    applyStimulus(3'd4, M_PC | ((op == OP_SW) ? 10'd0 : M_REG), rb(), rb(), "wb");
  endtask

  initial begin
    @(posedge clk);
    #1;
    doReset();

    runInstr(OP_ADDI, 0, 0);
    runInstr(OP_LW, 0, 3);
    runInstr(OP_SW, 0, 0);
    runInstr(OP_BEQ, 0, 0);
    runInstr(OP_JAL, 0, 0);
    runInstr(OP_RTYPE, 3, 0);
    checkOutput("directed/instret", instret, 32'd6);

    for (int n = 0; n < 300; n++)
      runInstr(legalOps[$urandom_range(0, 14)], $urandom_range(0, 3), $urandom_range(0, 3));

    // Reset in the middle of EXEC must abort at once without retiring.
    setDecoder(OP_ADDI);
    applyStimulus(3'd0, M_IMEM | M_IR, 1'b1, 1'b0, "abortFetch");
    applyStimulus(3'd1, 10'd0, 1'b0, 1'b0, "abortDecode");
    #1;
    checkOutput("abort/aluOutWrite", 32'(aluOutWrite), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("abort/state", 32'(state), 32'd0);
    checkOutput("abort/flags", 32'(dutFlags), 32'd0);
    checkOutput("abort/instret", instret, 32'd0);
    @(posedge clk);
    #1;
    releaseReset();
    runInstr(OP_J, 1, 0);

    runInstr(6'h3F, 0, 0);
    doReset();
    runInstr(OP_ADDI, TMO, 0);
    doReset();
    runInstr(OP_LW, 0, TMO);
    doReset();
    runInstr(OP_SW, 2, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule

// File: doc/mc_sequencer.md
# mc_sequencer

Multi-cycle sequencer for the MIPS core. It steps one instruction at a time through FETCH, DECODE, EXEC, MEM and WB, and handshakes with instruction and data memory. Each architectural write enable (PC, IR, ALUOut, MDR, register file, data memory) fires only in its phase. It sits between the combinational decoder outputs and the datapath, gates them in time, counts retired instructions and halts on illegal opcodes or memory timeouts.

## Interface
Parameters:
- ACK_TIMEOUT, 255: maximum wait cycles for imemAck/dmemAck before bus error; 0 disables the watchdog.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- opcode  input  6  opcode field of the current IR.
- ctrlNPCFrom  input  2  decoder next-PC select (`NPC_BRANCH`, `NPC_JMP`, else sequential).
- ctrlMemRead  input  1  decoder: instruction is a load.
- ctrlMemWrite  input  1  decoder: instruction is a store.
- ctrlRegWrite  input  1  decoder: instruction writes the register file.
- imemReq  output  1  instruction fetch request.
- imemAck  input  1  instruction word valid this cycle.
- dmemReq  output  1  data memory request.
- dmemWe  output  1  data memory write; valid only with dmemReq.
- dmemAck  input  1  data access complete (read data valid) this cycle.
- irWrite  output  1  load IR.
- pcWrite  output  1  load PC from NPC.
- aluOutWrite  output  1  load ALUOut register.
- mdrWrite  output  1  load memory data register.
- regWrite  output  1  register-file write enable.
- state  output  3  current state: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
- halted  output  1  in HALT.
- busErr  output  1  sticky; HALT entered by timeout.
- instret  output  32  retired-instruction count.

## Operation
- Legal opcodes: `INSTR_OP_RTYPE`, `ADDI`, `ADDIU`, `ANDI`, `ORI`, `LUI`, `XORI`, `SW`, `LW`, `BEQ`, `BNE`, `SLTI`, `SLTIU`, `J`, `JAL`.
- FETCH:
  - imemReq=1 until imemAck.
  - On ack: irWrite=1, go to DECODE.
- DECODE:
  - Illegal opcode: go to HALT, with no enables.
  - J: pcWrite=1, retire, go to FETCH.
  - JAL: pcWrite=1 and regWrite=ctrlRegWrite, retire, go to FETCH.
  - Otherwise: go to EXEC.
- EXEC:
  - aluOutWrite=1.
  - ctrlNPCFrom==`NPC_BRANCH`: pcWrite=1, retire, go to FETCH. The datapath NPC resolves taken or not-taken.
  - ctrlMemRead|ctrlMemWrite: go to MEM.
  - Otherwise: go to WB.
- MEM:
  - dmemReq=1 and dmemWe=ctrlMemWrite until dmemAck.
  - On ack with a store: pcWrite=1, retire, go to FETCH.
  - On ack with a load: mdrWrite=1, go to WB.
- WB: regWrite=ctrlRegWrite, pcWrite=1, retire, go to FETCH.
- HALT: terminal until rst. All enables and requests are 0; halted=1.
- Retire: instret increments by 1 in the same cycle pcWrite is asserted. pcWrite is asserted exactly once per instruction. instret wraps 0xFFFFFFFF to 0.
- Watchdog:
  - waitCnt clears on entry to FETCH or MEM and increments each cycle while waiting without ack.
  - When waitCnt==ACK_TIMEOUT-1 and no ack arrives: go to HALT and set busErr=1.
  - An ack in the limit cycle wins and proceeds normally.
  - waitCnt width is clog2(ACK_TIMEOUT+1), minimum 1.
- Ack in any state other than the one waiting on it is ignored.

## Timing
- While rst=1, all outputs are 0 except state=FETCH: imemReq, dmemReq, dmemWe, all write enables, halted, busErr, instret.
- On the first edge after rst falls, imemReq=1.
- imemReq, dmemReq, dmemWe, halted and state are Moore outputs (state only).
- irWrite, mdrWrite and the MEM/FETCH-phase pcWrite are Mealy outputs, qualified by the same-cycle ack.
- Cycles per instruction with zero-wait memory (ack in the request's first cycle):
  - J/JAL: 2.
  - Branch: 3.
  - R-type and immediate ALU ops: 4.
  - SW: 4.
  - LW: 5.
- Each wait cycle on imem or dmem adds 1.
- Reset asserted mid-instruction aborts it immediately. There is no partial retire and no enable in the reset cycle.
- Decoder inputs must be stable from DECODE through the instruction's last cycle; IR only changes on irWrite.

## Test plan
- Reset then ADDI with imemAck tied high: state sequence 0,1,2,4,0. irWrite at cycle 1, aluOutWrite at 3, regWrite and pcWrite at 4. instret 0 to 1.
- LW with dmemAck delayed 3 cycles: dmemReq=1 and dmemWe=0 for 4 cycles. mdrWrite only in the ack cycle, then WB with regWrite=1. 8 cycles total, instret +1.
- SW then BEQ back-to-back, zero wait: SW dmemWe=1 and regWrite never 1. BEQ reaches FETCH after EXEC with pcWrite=1. instret +2 in 7 cycles.
- JAL: regWrite=1 and pcWrite=1 in the DECODE cycle; instret +1 after 2 cycles.
- Opcode 6'h3F: DECODE goes to HALT; halted=1, busErr=0, no enables ever again, and subsequent imemAck is ignored.
- ACK_TIMEOUT=4 with imemAck never asserted: HALT after 4 FETCH cycles, busErr=1. Repeat with ack in the 4th cycle: normal DECODE. Assert rst mid-EXEC: all outputs 0 at once, state=FETCH, instret=0.
